mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 187 ++++++++++++++++++
 tb/tb_mem_stage.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// MEM pipeline stage: drives the data-memory handshake, stalls the front of the
// pipeline while memory is waiting, and produces the MEM/WB register.
module mem_stage #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        EXMEMRegWrite,
    input  logic        EXMEMMemtoReg,
    input  logic        EXMEMMemRead,
    input  logic        EXMEMMemWrite,
    input  logic [31:0] EXMEMReadAddress,
    input  logic [31:0] EXMEMWriteData,
    input  logic [4:0]  EXMEMDst,
    output logic        DMemReq,
    output logic        DMemWe,
    output logic [31:0] DMemAddr,
    output logic [31:0] DMemWData,
    input  logic [31:0] DMemRData,
    input  logic        DMemReady,
    output logic        MEMWBRegWrite,
    output logic        MEMWBMemtoReg,
    output logic [31:0] MEMWBReadData,
    output logic [31:0] MEMWBALUResult,
    output logic [4:0]  MEMWBDst,
    output logic [31:0] MEMForwarding,
    output logic        MEMStall,
    output logic        MEMError
);

    localparam int unsigned CW = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_WAIT - 1);

    typedef enum logic {ST_IDLE, ST_WAIT} state_t;

    state_t      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0] h_addr_q, h_addr_d;
    logic [31:0] h_wdata_q, h_wdata_d;
    logic [4:0]  h_dst_q, h_dst_d;
    logic        h_rw_q, h_rw_d;
    logic        h_m2r_q, h_m2r_d;
    logic        h_we_q, h_we_d;
    logic        err_q, err_d;
    logic        wb_rw_q, wb_rw_d;
    logic        wb_m2r_q, wb_m2r_d;
    logic [31:0] wb_rdata_q, wb_rdata_d;
    logic [31:0] wb_alu_q, wb_alu_d;
    logic [4:0]  wb_dst_q, wb_dst_d;

    logic        pending;
    logic        req, we, stall;
    logic [31:0] addr, wdata;

    assign pending = EXMEMMemRead | EXMEMMemWrite;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        h_addr_d   = h_addr_q;
        h_wdata_d  = h_wdata_q;
        h_dst_d    = h_dst_q;
        h_rw_d     = h_rw_q;
        h_m2r_d    = h_m2r_q;
        h_we_d     = h_we_q;
        err_d      = err_q;
        wb_rw_d    = 1'b0;
        wb_m2r_d   = 1'b0;
        wb_rdata_d = '0;
        wb_alu_d   = '0;
        wb_dst_d   = '0;
        req        = 1'b0;
        we         = 1'b0;
        stall      = 1'b0;
        addr       = EXMEMReadAddress;
        wdata      = EXMEMWriteData;

        case (state_q)
            ST_IDLE: begin
                if (pending) begin
                    req       = 1'b1;
                    we        = EXMEMMemWrite;
                    h_addr_d  = EXMEMReadAddress;
                    h_wdata_d = EXMEMWriteData;
                    h_dst_d   = EXMEMDst;
                    h_rw_d    = EXMEMRegWrite;
                    h_m2r_d   = EXMEMMemtoReg;
                    h_we_d    = EXMEMMemWrite;
                    // Conflicting read+write is performed as a write and flagged.
                    if (EXMEMMemRead && EXMEMMemWrite) err_d = 1'b1;
                    if (DMemReady) begin
                        wb_rw_d    = EXMEMRegWrite;
                        wb_m2r_d   = EXMEMMemtoReg;
                        wb_rdata_d = EXMEMMemWrite ? '0 : DMemRData;
                        wb_alu_d   = EXMEMReadAddress;
                        wb_dst_d   = EXMEMDst;
                    end else begin
                        stall   = 1'b1;
                        state_d = ST_WAIT;
                        cnt_d   = '0;
                    end
                end else begin
                    wb_rw_d  = EXMEMRegWrite;
                    wb_m2r_d = EXMEMMemtoReg;
                    wb_alu_d = EXMEMReadAddress;
                    wb_dst_d = EXMEMDst;
                end
            end
            ST_WAIT: begin
                addr  = h_addr_q;
                wdata = h_wdata_q;
                // Last permitted wait cycle: abandon the access and release the
                // pipeline so the faulting instruction moves on as a bubble.
                if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    req = 1'b1;
                    we  = h_we_q;
                    if (DMemReady) begin
                        wb_rw_d    = h_rw_q;
                        wb_m2r_d   = h_m2r_q;
                        wb_rdata_d = h_we_q ? '0 : DMemRData;
                        wb_alu_d   = h_addr_q;
                        wb_dst_d   = h_dst_q;
                        state_d    = ST_IDLE;
                        cnt_d      = '0;
                    end else begin
                        stall = 1'b1;
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            h_addr_q   <= '0;
            h_wdata_q  <= '0;
            h_dst_q    <= '0;
            h_rw_q     <= 1'b0;
            h_m2r_q    <= 1'b0;
            h_we_q     <= 1'b0;
            err_q      <= 1'b0;
            wb_rw_q    <= 1'b0;
            wb_m2r_q   <= 1'b0;
            wb_rdata_q <= '0;
            wb_alu_q   <= '0;
            wb_dst_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            h_addr_q   <= h_addr_d;
            h_wdata_q  <= h_wdata_d;
            h_dst_q    <= h_dst_d;
            h_rw_q     <= h_rw_d;
            h_m2r_q    <= h_m2r_d;
            h_we_q     <= h_we_d;
            err_q      <= err_d;
            wb_rw_q    <= wb_rw_d;
            wb_m2r_q   <= wb_m2r_d;
            wb_rdata_q <= wb_rdata_d;
            wb_alu_q   <= wb_alu_d;
            wb_dst_q   <= wb_dst_d;
        end
    end

    // Handshake outputs are combinational, so gate them with reset directly.
    assign DMemReq        = req & reset_n;
    assign DMemWe         = we & reset_n;
    assign MEMStall       = stall & reset_n;
    assign DMemAddr       = addr;
    assign DMemWData      = wdata;
    assign MEMForwarding  = EXMEMReadAddress;
    assign MEMError       = err_q;
    assign MEMWBRegWrite  = wb_rw_q;
    assign MEMWBMemtoReg  = wb_m2r_q;
    assign MEMWBReadData  = wb_rdata_q;
    assign MEMWBALUResult = wb_alu_q;
    assign MEMWBDst       = wb_dst_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed vectors, multi-cycle sequences,
// and random traffic against a transaction-level reference model.
module tb_mem_stage;

    localparam int MAXW = 15;

    logic        clock, reset_n;
    logic        rw_i, m2r_i, rd_i, wr_i;
    logic [31:0] addr_i, wdata_i, rdata_i;
    logic [4:0]  dst_i;
    logic        ready_i;
    logic        DMemReq, DMemWe, MEMWBRegWrite, MEMWBMemtoReg, MEMStall, MEMError;
    logic [31:0] DMemAddr, DMemWData, MEMWBReadData, MEMWBALUResult, MEMForwarding;
    logic [4:0]  MEMWBDst;

    int checks = 0;
    int errors = 0;

    mem_stage #(.MAX_WAIT(MAXW)) dut (
        .clock(clock), .reset_n(reset_n),
        .EXMEMRegWrite(rw_i), .EXMEMMemtoReg(m2r_i),
        .EXMEMMemRead(rd_i), .EXMEMMemWrite(wr_i),
        .EXMEMReadAddress(addr_i), .EXMEMWriteData(wdata_i), .EXMEMDst(dst_i),
        .DMemReq(DMemReq), .DMemWe(DMemWe), .DMemAddr(DMemAddr), .DMemWData(DMemWData),
        .DMemRData(rdata_i), .DMemReady(ready_i),
        .MEMWBRegWrite(MEMWBRegWrite), .MEMWBMemtoReg(MEMWBMemtoReg),
        .MEMWBReadData(MEMWBReadData), .MEMWBALUResult(MEMWBALUResult), .MEMWBDst(MEMWBDst),
        .MEMForwarding(MEMForwarding), .MEMStall(MEMStall), .MEMError(MEMError)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rd, input logic wr, input logic rw, input logic m2r,
                         input logic [31:0] a, input logic [31:0] wd, input logic [4:0] d,
                         input logic rdy, input logic [31:0] rdat);
        rd_i = rd; wr_i = wr; rw_i = rw; m2r_i = m2r;
        addr_i = a; wdata_i = wd; dst_i = d; ready_i = rdy; rdata_i = rdat;
    endtask

    task automatic chk_wb_zero(input string tag);
        chk({tag, ".wb_rw"}, 32'(MEMWBRegWrite), 32'd0);
        chk({tag, ".wb_m2r"}, 32'(MEMWBMemtoReg), 32'd0);
        chk({tag, ".wb_rdata"}, MEMWBReadData, 32'd0);
        chk({tag, ".wb_alu"}, MEMWBALUResult, 32'd0);
        chk({tag, ".wb_dst"}, 32'(MEMWBDst), 32'd0);
    endtask

    // Resets the DUT from the post-edge phase; leaves the bench at posedge+1.
    task automatic do_reset(input string tag);
        drive(0, 0, 0, 0, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
        #1 reset_n = 1'b0;
        #1;
        chk({tag, ".req"}, 32'(DMemReq), 32'd0);
        chk({tag, ".stall"}, 32'(MEMStall), 32'd0);
        chk({tag, ".err"}, 32'(MEMError), 32'd0);
        chk_wb_zero(tag);
        @(posedge clock);
        #1 reset_n = 1'b1;
    endtask

    typedef struct {
        logic rd, wr, rw, m2r;
        logic [31:0] addr, wdata;
        logic [4:0] dst;
        logic ready;
        logic [31:0] rdata;
        logic e_req, e_we, e_stall, e_rw, e_m2r;
        logic [31:0] e_rdata;
    } vec_t;

    typedef struct {
        logic rd, wr, rw, m2r;
        logic [31:0] addr, wdata;
        logic [4:0] dst;
    } ins_t;

    // Reference model: one outstanding access plus the count of wait cycles spent on it.
    bit          m_busy;
    int          m_waited;
    ins_t        m_acc;
    bit          m_err;
    bit          m_valid;
    logic        m_rw, m_m2r;
    logic [31:0] m_rdata, m_alu;
    logic [4:0]  m_dst;

    task automatic model_reset();
        m_busy = 0; m_waited = 0; m_err = 0; m_valid = 1;
        m_rw = 0; m_m2r = 0; m_rdata = 0; m_alu = 0; m_dst = 0;
    endtask

    task automatic model_retire(input ins_t x, input logic [31:0] rd_data);
        m_valid = 1;
        m_rw = x.rw; m_m2r = x.m2r; m_dst = x.dst; m_alu = x.addr;
        m_rdata = (x.rd && !x.wr) ? rd_data : 32'h0;
    endtask

    task automatic model_bubble();
        m_valid = 0; m_rw = 0; m_m2r = 0;
    endtask

    task automatic rand_cycle(input int pct);
        ins_t in;
        int   sel;
        bit   e_req, e_stall, e_we;
        logic [31:0] e_addr, e_wdata;
        sel = $urandom_range(0, 19);
        in.rd = (sel <= 6) || (sel == 13);
        in.wr = (sel >= 7 && sel <= 13);
        in.rw = 1'($urandom_range(0, 1));
        in.m2r = 1'($urandom_range(0, 1));
        in.addr = $urandom;
        in.wdata = $urandom;
        in.dst = 5'($urandom_range(0, 31));
        drive(in.rd, in.wr, in.rw, in.m2r, in.addr, in.wdata, in.dst,
              1'($urandom_range(0, 99) < pct), $urandom);
        if (!m_busy) begin
            e_req = in.rd || in.wr; e_we = in.wr; e_addr = in.addr; e_wdata = in.wdata;
            e_stall = e_req && !ready_i;
        end else if (m_waited + 1 == MAXW) begin
            e_req = 0; e_we = 0; e_stall = 0; e_addr = m_acc.addr; e_wdata = m_acc.wdata;
        end else begin
            e_req = 1; e_we = m_acc.wr; e_addr = m_acc.addr; e_wdata = m_acc.wdata;
            e_stall = !ready_i;
        end
        #2;
        chk("rnd.req", 32'(DMemReq), 32'(e_req));
        chk("rnd.stall", 32'(MEMStall), 32'(e_stall));
        chk("rnd.fwd", MEMForwarding, in.addr);
        if (e_req) begin
            chk("rnd.we", 32'(DMemWe), 32'(e_we));
            chk("rnd.addr", DMemAddr, e_addr);
            if (e_we) chk("rnd.wdata", DMemWData, e_wdata);
        end
        @(posedge clock);
        if (!m_busy) begin
            if (in.rd && in.wr) m_err = 1;
            if (!(in.rd || in.wr)) model_retire(in, 32'h0);
            else if (ready_i) model_retire(in, rdata_i);
            else begin m_busy = 1; m_waited = 0; m_acc = in; model_bubble(); end
        end else if (m_waited + 1 == MAXW) begin
            m_err = 1; m_busy = 0; model_bubble();
        end else if (ready_i) begin
            m_busy = 0; model_retire(m_acc, rdata_i);
        end else begin
            m_waited++; model_bubble();
        end
        #1;
        chk("rnd.wb_rw", 32'(MEMWBRegWrite), 32'(m_rw));
        chk("rnd.wb_m2r", 32'(MEMWBMemtoReg), 32'(m_m2r));
        chk("rnd.err", 32'(MEMError), 32'(m_err));
        if (m_valid) begin
            chk("rnd.wb_rdata", MEMWBReadData, m_rdata);
            chk("rnd.wb_alu", MEMWBALUResult, m_alu);
            chk("rnd.wb_dst", 32'(MEMWBDst), 32'(m_dst));
        end
    endtask

    vec_t vecs[6];
    int   req_cnt, stall_cnt;

    initial begin
        vecs[0] = '{0,0,1,0, 32'h12345678, 32'h0, 5'd5, 0, 32'h0,           0,0,0,1,0, 32'h0};
        vecs[1] = '{1,0,1,1, 32'h44332211, 32'h0, 5'd2, 1, 32'h55667788,    1,0,0,1,1, 32'h55667788};
        vecs[2] = '{0,1,0,0, 32'h00000040, 32'hCAFEF00D, 5'd0, 1, 32'hFFFFFFFF, 1,1,0,0,0, 32'h0};
        vecs[3] = '{0,0,1,0, 32'hFFFFFFFC, 32'h0, 5'd31, 1, 32'hABCDABCD,   0,0,0,1,0, 32'h0};
        vecs[4] = '{0,0,0,0, 32'h00000000, 32'h0, 5'd0, 0, 32'h0,           0,0,0,0,0, 32'h0};
        vecs[5] = '{1,0,1,1, 32'hFFFFFFFC, 32'h0, 5'd31, 1, 32'hDEADBEEF,   1,0,0,1,1, 32'hDEADBEEF};

        reset_n = 1'b0;
        drive(0, 0, 0, 0, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
        #12;
        chk("por.req", 32'(DMemReq), 32'd0);
        chk("por.we", 32'(DMemWe), 32'd0);
        chk("por.err", 32'(MEMError), 32'd0);
        chk_wb_zero("por");
        @(posedge clock);
        #1 reset_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            drive(vecs[i].rd, vecs[i].wr, vecs[i].rw, vecs[i].m2r, vecs[i].addr,
                  vecs[i].wdata, vecs[i].dst, vecs[i].ready, vecs[i].rdata);
            #2;
            chk($sformatf("vec%0d.req", i), 32'(DMemReq), 32'(vecs[i].e_req));
            chk($sformatf("vec%0d.we", i), 32'(DMemWe), 32'(vecs[i].e_we));
            chk($sformatf("vec%0d.stall", i), 32'(MEMStall), 32'(vecs[i].e_stall));
            chk($sformatf("vec%0d.fwd", i), MEMForwarding, vecs[i].addr);
            if (vecs[i].e_req) chk($sformatf("vec%0d.addr", i), DMemAddr, vecs[i].addr);
            @(posedge clock);
            #1;
            chk($sformatf("vec%0d.wb_rw", i), 32'(MEMWBRegWrite), 32'(vecs[i].e_rw));
            chk($sformatf("vec%0d.wb_m2r", i), 32'(MEMWBMemtoReg), 32'(vecs[i].e_m2r));
            chk($sformatf("vec%0d.wb_rdata", i), MEMWBReadData, vecs[i].e_rdata);
            chk($sformatf("vec%0d.wb_alu", i), MEMWBALUResult, vecs[i].addr);
            chk($sformatf("vec%0d.wb_dst", i), 32'(MEMWBDst), 32'(vecs[i].dst));
            chk($sformatf("vec%0d.err", i), 32'(MEMError), 32'd0);
        end

        // Read and write asserted together
        drive(1, 1, 1, 1, 32'h8, 32'h13579246, 5'd3, 1'b1, 32'h77777777);
        #2;
        chk("rw.req", 32'(DMemReq), 32'd1);
        chk("rw.we", 32'(DMemWe), 32'd1);
        chk("rw.wdata", DMemWData, 32'h13579246);
        @(posedge clock);
        #1;
        chk("rw.err", 32'(MEMError), 32'd1);
        chk("rw.wb_rdata", MEMWBReadData, 32'h0);
        drive(0, 0, 0, 0, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
        @(posedge clock);
        #1;
        chk("rw.sticky", 32'(MEMError), 32'd1);
        do_reset("rst1");

        // Store with three wait cycles; EX/MEM inputs scrambled while waiting
        req_cnt = 0; stall_cnt = 0;
        for (int c = 0; c < 4; c++) begin
            if (c == 0) drive(0, 1, 0, 0, 32'h100, 32'h11223344, 5'd7, 1'b0, 32'h0);
            else drive(1, 0, 1, 1, 32'hDEAD0000 + 32'(c), 32'h0, 5'd9, c == 3, 32'hAAAA5555);
            #2;
            if (DMemReq) req_cnt++;
            if (MEMStall) stall_cnt++;
            chk($sformatf("st.c%0d.addr", c), DMemAddr, 32'h100);
            chk($sformatf("st.c%0d.we", c), 32'(DMemWe), 32'd1);
            chk($sformatf("st.c%0d.wdata", c), DMemWData, 32'h11223344);
            @(posedge clock);
            #1;
            chk($sformatf("st.c%0d.wb_rw", c), 32'(MEMWBRegWrite), 32'd0);
        end
        chk("st.req_cycles", 32'(req_cnt), 32'd4);
        chk("st.stall_cycles", 32'(stall_cnt), 32'd3);
        chk("st.wb_rdata", MEMWBReadData, 32'h0);
        chk("st.wb_alu", MEMWBALUResult, 32'h100);
        chk("st.wb_dst", 32'(MEMWBDst), 32'd7);
        do_reset("rst2");

        // Read that never completes
        drive(1, 0, 1, 1, 32'h200, 32'h0, 5'd4, 1'b0, 32'h0);
        #2;
        chk("to.idle.stall", 32'(MEMStall), 32'd1);
        @(posedge clock);
        #1;
        for (int k = 1; k <= MAXW; k++) begin
            #2;
            chk($sformatf("to.w%0d.req", k), 32'(DMemReq), 32'(k < MAXW));
            chk($sformatf("to.w%0d.stall", k), 32'(MEMStall), 32'(k < MAXW));
            @(posedge clock);
            #1;
            chk($sformatf("to.w%0d.err", k), 32'(MEMError), 32'(k == MAXW));
            chk($sformatf("to.w%0d.wb_rw", k), 32'(MEMWBRegWrite), 32'd0);
        end
        drive(0, 0, 1, 0, 32'h0000ABCD, 32'h0, 5'd6, 1'b1, 32'h0);
        #2;
        chk("to.after.req", 32'(DMemReq), 32'd0);
        @(posedge clock);
        #1;
        chk("to.after.wb_alu", MEMWBALUResult, 32'h0000ABCD);
        chk("to.after.wb_rw", 32'(MEMWBRegWrite), 32'd1);
        chk("to.after.err", 32'(MEMError), 32'd1);
        do_reset("rst3");

        // Asynchronous reset on the second wait cycle
        drive(0, 1, 1, 0, 32'h300, 32'h99, 5'd8, 1'b0, 32'h0);
        @(posedge clock);
        #1;
        #2;
        chk("rw2.w1.req", 32'(DMemReq), 32'd1);
        @(posedge clock);
        #3 reset_n = 1'b0;
        #1;
        chk("rw2.req", 32'(DMemReq), 32'd0);
        chk("rw2.stall", 32'(MEMStall), 32'd0);
        chk("rw2.err", 32'(MEMError), 32'd0);
        chk_wb_zero("rw2");
        drive(0, 0, 1, 0, 32'h0BADF00D, 32'h0, 5'd9, 1'b0, 32'h0);
        @(posedge clock);
        #1 reset_n = 1'b1;
        #2;
        chk("rw2.rel.req", 32'(DMemReq), 32'd0);
        @(posedge clock);
        #1;
        chk("rw2.rel.wb_rw", 32'(MEMWBRegWrite), 32'd1);
        chk("rw2.rel.wb_alu", MEMWBALUResult, 32'h0BADF00D);
        chk("rw2.rel.wb_dst", 32'(MEMWBDst), 32'd9);
        chk("rw2.rel.err", 32'(MEMError), 32'd0);

        do_reset("rst4");
        model_reset();
        for (int b = 0; b < 30; b++) begin
            int pct;
            pct = (b % 3 == 0) ? 90 : ((b % 3 == 1) ? 35 : 2);
            for (int n = 0; n < 50; n++) rand_cycle(pct);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
